datapath_ctrl: RTL and testbench

Moore state machine that sequences the 16-bit register-file/shifter/ALU datapath one instruction at a time. It sits between the instruction register and the datapath. It accepts an opcode/op pair on a start strobe and emits the per-cycle load, select, write and ALUop controls. It signals completion by returning to WAIT.

---
 rtl/datapath_pkg.sv | 44 ++++
 rtl/datapath_ctrl_if.sv | 31 +++
 rtl/datapath_ctrl_outdec.sv | 75 +++++++
 rtl/datapath_ctrl.sv | 75 +++++++
 tb/tb_datapath_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared types and encodings for the 16-bit datapath controller:
// FSM states, instruction fields and datapath control encodings.
package datapath_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE_RD  = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    // MOV accepts only the imm and reg sub-ops; every ALU sub-op is defined.
    function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] op);
        return ((opc == OPC_MOV) && ((op == OP_MOV_IMM) || (op == OP_MOV_REG))) ||
               (opc == OPC_ALU);
    endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Instruction-side strobe/opcode inputs and datapath control outputs.
// master = controller, slave = instruction register / datapath side.
interface datapath_ctrl_if;
    import datapath_pkg::*;

    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic [1:0] vsel;
    logic       write;
    logic [1:0] ALUop;
    logic       illegal;

    modport master (
        input  s, opcode, op,
        output w, nsel, loada, loadb, loadc, loads, asel, vsel, write, ALUop, illegal
    );

    modport slave (
        output s, opcode, op,
        input  w, nsel, loada, loadb, loadc, loads, asel, vsel, write, ALUop, illegal
    );

endinterface

// File: rtl/datapath_ctrl_outdec.sv
// Moore output decoder: maps (state, latched opcode/op) to datapath controls.
module datapath_ctrl_outdec
    import datapath_pkg::*;
(
    input  state_e     state_i,
    input  logic [2:0] opcode_i,
    input  logic [1:0] op_i,
    output logic       w_o,
    output logic [2:0] nsel_o,
    output logic       loada_o,
    output logic       loadb_o,
    output logic       loadc_o,
    output logic       loads_o,
    output logic       asel_o,
    output logic [1:0] vsel_o,
    output logic       write_o,
    output logic [1:0] ALUop_o,
    output logic       illegal_o
);

    always_comb begin
        w_o       = 1'b0;
        nsel_o    = NSEL_NONE;
        loada_o   = 1'b0;
        loadb_o   = 1'b0;
        loadc_o   = 1'b0;
        loads_o   = 1'b0;
        asel_o    = 1'b0;
        vsel_o    = VSEL_C;
        write_o   = 1'b0;
        ALUop_o   = ALU_ADD;
        illegal_o = 1'b0;

        case (state_i)
            S_WAIT:   w_o = 1'b1;
            S_DECODE: illegal_o = !is_legal(opcode_i, op_i);
            S_GET_A: begin
                nsel_o  = NSEL_RN;
                loada_o = 1'b1;
            end
            S_GET_B: begin
                nsel_o  = NSEL_RM;
                loadb_o = 1'b1;
            end
            S_EXEC: begin
                // MOV reg passes B through the adder with A forced to zero.
                if (opcode_i == OPC_MOV) begin
                    asel_o  = 1'b1;
                    loadc_o = 1'b1;
                end else begin
                    loads_o = 1'b1;
                    loadc_o = (op_i != OP_CMP);
                    case (op_i)
                        OP_ADD:  ALUop_o = ALU_ADD;
                        OP_CMP:  ALUop_o = ALU_SUB;
                        OP_AND:  ALUop_o = ALU_AND;
                        default: ALUop_o = ALU_NOT;
                    endcase
                end
            end
            S_WRITE_RD: begin
                nsel_o  = NSEL_RD;
                vsel_o  = VSEL_C;
                write_o = 1'b1;
            end
            S_WRITE_IMM: begin
                nsel_o  = NSEL_RN;
                vsel_o  = VSEL_IMM;
                write_o = 1'b1;
            end
            default: w_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the register-file/shifter/ALU datapath:
// state register, opcode/op latch and next-state logic.
module datapath_ctrl
    import datapath_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    datapath_ctrl_if.master  bus
);

    state_e     state_q, state_d;
    logic [2:0] opcode_q, opcode_d;
    logic [1:0] op_q, op_d;

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        op_d     = op_q;

        case (state_q)
            S_WAIT: begin
                if (bus.s) begin
                    opcode_d = bus.opcode;
                    op_d     = bus.op;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!is_legal(opcode_q, op_q))
                    state_d = S_WAIT;
                else if (opcode_q == OPC_MOV)
                    state_d = (op_q == OP_MOV_IMM) ? S_WRITE_IMM : S_GET_B;
                else
                    state_d = (op_q == OP_MVN) ? S_GET_B : S_GET_A;
            end
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_EXEC;
            // CMP only updates status, so it has no write-back cycle.
            S_EXEC:      state_d = ((opcode_q == OPC_ALU) && (op_q == OP_CMP)) ? S_WAIT : S_WRITE_RD;
            S_WRITE_RD:  state_d = S_WAIT;
            S_WRITE_IMM: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_WAIT;
            opcode_q <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op_q     <= op_d;
        end
    end

    datapath_ctrl_outdec u_outdec (
        .state_i   (state_q),
        .opcode_i  (opcode_q),
        .op_i      (op_q),
        .w_o       (bus.w),
        .nsel_o    (bus.nsel),
        .loada_o   (bus.loada),
        .loadb_o   (bus.loadb),
        .loadc_o   (bus.loadc),
        .loads_o   (bus.loads),
        .asel_o    (bus.asel),
        .vsel_o    (bus.vsel),
        .write_o   (bus.write),
        .ALUop_o   (bus.ALUop),
        .illegal_o (bus.illegal)
    );

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl with a small register-file/ALU model
// driven by the controller outputs (Rn=R0, Rm=R1, Rd=R2, sximm8=0x0005).
module tb_datapath_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    datapath_ctrl_if bus ();

    datapath_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {w, nsel, loada, loadb, loadc, loads, asel, vsel, write, ALUop, illegal}
    logic [14:0] outs;
    assign outs = {bus.w, bus.nsel, bus.loada, bus.loadb, bus.loadc, bus.loads,
                   bus.asel, bus.vsel, bus.write, bus.ALUop, bus.illegal};

    localparam logic [14:0] O_WAIT  = {1'b1, 3'b000, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
    localparam logic [14:0] O_NONE  = {1'b0, 3'b000, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
    localparam logic [14:0] O_ILL   = {1'b0, 3'b000, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1};
    localparam logic [14:0] O_GETA  = {1'b0, 3'b001, 4'b1000, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
    localparam logic [14:0] O_GETB  = {1'b0, 3'b100, 4'b0100, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
    localparam logic [14:0] O_XADD  = {1'b0, 3'b000, 4'b0011, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
    localparam logic [14:0] O_XCMP  = {1'b0, 3'b000, 4'b0001, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
    localparam logic [14:0] O_XAND  = {1'b0, 3'b000, 4'b0011, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0};
    localparam logic [14:0] O_XMVN  = {1'b0, 3'b000, 4'b0011, 1'b0, 2'b00, 1'b0, 2'b11, 1'b0};
    localparam logic [14:0] O_XMOVR = {1'b0, 3'b000, 4'b0010, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0};
    localparam logic [14:0] O_WRD   = {1'b0, 3'b010, 4'b0000, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0};
    localparam logic [14:0] O_WIMM  = {1'b0, 3'b001, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0};

    // Datapath model
    logic [15:0] r0 = 16'hE3AD;
    logic [15:0] r1 = 16'h438B;
    logic [15:0] r2 = 16'h0000;
    logic [15:0] ra = 16'h0000;
    logic [15:0] rb = 16'h0000;
    logic [15:0] rc = 16'h0000;
    logic        zf = 1'b0;
    logic [15:0] rsel, ain, alu_out;

    always_comb begin
        rsel = 16'h0000;
        case (bus.nsel)
            3'b001:  rsel = r0;
            3'b010:  rsel = r2;
            3'b100:  rsel = r1;
            default: rsel = 16'h0000;
        endcase
        ain = bus.asel ? 16'h0000 : ra;
        case (bus.ALUop)
            2'b00:   alu_out = ain + rb;
            2'b01:   alu_out = ain - rb;
            2'b10:   alu_out = ain & rb;
            default: alu_out = ~rb;
        endcase
    end

    always @(posedge clk) begin
        if (bus.loada) ra <= rsel;
        if (bus.loadb) rb <= rsel;
        if (bus.loadc) rc <= alu_out;
        if (bus.loads) zf <= (alu_out == 16'h0000);
        if (bus.write) begin
            case (bus.nsel)
                3'b001:  r0 <= (bus.vsel == 2'b10) ? 16'h0005 : rc;
                3'b010:  r2 <= (bus.vsel == 2'b10) ? 16'h0005 : rc;
                3'b100:  r1 <= (bus.vsel == 2'b10) ? 16'h0005 : rc;
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [2:0] opc, input logic [1:0] op);
        bus.s      = 1'b1;
        bus.opcode = opc;
        bus.op     = op;
    endtask

    initial begin
        reset      = 1'b1;
        bus.s      = 1'b1;
        bus.opcode = 3'b101;
        bus.op     = 2'b00;
        step();
        chk("reset_outs", {1'b0, outs}, {1'b0, O_WAIT});
        step();
        chk("reset_overrides_s", {1'b0, outs}, {1'b0, O_WAIT});
        reset = 1'b0;
        bus.s = 1'b0;
        step();
        chk("idle_wait", {1'b0, outs}, {1'b0, O_WAIT});

        // ADD R2 = R0 + R1
        start(3'b101, 2'b00);
        step(); chk("add_decode", {1'b0, outs}, {1'b0, O_NONE});
        bus.s = 1'b0;
        step(); chk("add_geta", {1'b0, outs}, {1'b0, O_GETA});
        step(); chk("add_getb", {1'b0, outs}, {1'b0, O_GETB});
        step(); chk("add_exec", {1'b0, outs}, {1'b0, O_XADD});
        step(); chk("add_wrd", {1'b0, outs}, {1'b0, O_WRD});
        step(); chk("add_done", {1'b0, outs}, {1'b0, O_WAIT});
        chk("add_r2", r2, 16'h2738);

        // CMP R0, R1
        start(3'b101, 2'b01);
        step(); chk("cmp_decode", {1'b0, outs}, {1'b0, O_NONE});
        bus.s = 1'b0;
        step(); chk("cmp_geta", {1'b0, outs}, {1'b0, O_GETA});
        step(); chk("cmp_getb", {1'b0, outs}, {1'b0, O_GETB});
        step(); chk("cmp_exec", {1'b0, outs}, {1'b0, O_XCMP});
        step(); chk("cmp_done", {1'b0, outs}, {1'b0, O_WAIT});
        chk("cmp_r2_kept", r2, 16'h2738);
        chk("cmp_z", {15'h0, zf}, 16'h0000);

        // MOV R0, #5 then MVN R2, R1 with s held high
        start(3'b110, 2'b10);
        step(); chk("movi_decode", {1'b0, outs}, {1'b0, O_NONE});
        bus.opcode = 3'b101;
        bus.op     = 2'b11;
        step(); chk("movi_wimm", {1'b0, outs}, {1'b0, O_WIMM});
        step(); chk("movi_done", {1'b0, outs}, {1'b0, O_WAIT});
        step(); chk("mvn_decode", {1'b0, outs}, {1'b0, O_NONE});
        bus.s = 1'b0;
        step(); chk("mvn_getb", {1'b0, outs}, {1'b0, O_GETB});
        step(); chk("mvn_exec", {1'b0, outs}, {1'b0, O_XMVN});
        step(); chk("mvn_wrd", {1'b0, outs}, {1'b0, O_WRD});
        step(); chk("mvn_done", {1'b0, outs}, {1'b0, O_WAIT});
        chk("movi_r0", r0, 16'h0005);
        chk("mvn_r2", r2, 16'hBC74);

        // Illegal opcode, then illegal MOV sub-op
        start(3'b000, 2'b00);
        step(); chk("ill_opc_pulse", {1'b0, outs}, {1'b0, O_ILL});
        bus.s = 1'b0;
        step(); chk("ill_opc_done", {1'b0, outs}, {1'b0, O_WAIT});
        start(3'b110, 2'b01);
        step(); chk("ill_op_pulse", {1'b0, outs}, {1'b0, O_ILL});
        bus.s = 1'b0;
        step(); chk("ill_op_done", {1'b0, outs}, {1'b0, O_WAIT});

        // MOV R2, R1
        start(3'b110, 2'b00);
        step(); chk("movr_decode", {1'b0, outs}, {1'b0, O_NONE});
        bus.s = 1'b0;
        step(); chk("movr_getb", {1'b0, outs}, {1'b0, O_GETB});
        step(); chk("movr_exec", {1'b0, outs}, {1'b0, O_XMOVR});
        step(); chk("movr_wrd", {1'b0, outs}, {1'b0, O_WRD});
        step(); chk("movr_done", {1'b0, outs}, {1'b0, O_WAIT});
        chk("movr_r2", r2, 16'h438B);

        // Reset asserted during EXEC of an ADD
        start(3'b101, 2'b00);
        step(); bus.s = 1'b0;
        step(); step();
        step(); chk("rst_add_exec", {1'b0, outs}, {1'b0, O_XADD});
        reset = 1'b1;
        step(); chk("rst_mid_outs", {1'b0, outs}, {1'b0, O_WAIT});
        reset = 1'b0;
        step(); chk("rst_mid_after", {1'b0, outs}, {1'b0, O_WAIT});
        chk("rst_mid_r2", r2, 16'h438B);

        // AND with opcode/op toggling after accept
        start(3'b101, 2'b10);
        step(); chk("and_decode", {1'b0, outs}, {1'b0, O_NONE});
        bus.s = 1'b0;
        bus.opcode = ~bus.opcode; bus.op = ~bus.op;
        step(); chk("and_geta", {1'b0, outs}, {1'b0, O_GETA});
        bus.opcode = ~bus.opcode; bus.op = ~bus.op;
        step(); chk("and_getb", {1'b0, outs}, {1'b0, O_GETB});
        bus.opcode = ~bus.opcode; bus.op = ~bus.op;
        step(); chk("and_exec", {1'b0, outs}, {1'b0, O_XAND});
        bus.opcode = ~bus.opcode; bus.op = ~bus.op;
        step(); chk("and_wrd", {1'b0, outs}, {1'b0, O_WRD});
        bus.opcode = ~bus.opcode; bus.op = ~bus.op;
        step(); chk("and_done", {1'b0, outs}, {1'b0, O_WAIT});
        chk("and_r2", r2, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
